pwm_from_counter: RTL and testbench



---
 rtl/pwm_pkg.sv | 22 ++
 rtl/pwm_deadtime.sv | 46 ++++
 rtl/pwm_from_counter.sv | 147 ++++++++++++++
 tb/tb_pwm_from_counter.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the PWM stage fed by the free-running wrap counter.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARM       = 2'd1,
        RUN       = 2'd2,
        STOP_PEND = 2'd3
    } pwm_state_e;

    localparam int WIDTH_DEF = 4;
    localparam int MAX_DUTY  = 2 ** WIDTH_DEF;

    function automatic logic [31:0] clamp_duty(input logic [31:0] duty, input logic [31:0] max_duty);
        if (duty > max_duty) begin
            clamp_duty = max_duty;
        end else begin
            clamp_duty = duty;
        end
    endfunction

endpackage

// File: rtl/pwm_deadtime.sv
// Dead-time shaper: delays each rising edge of PWM/PWM_N by DEAD cycles, keeps
// falling edges at one cycle and swallows pulses no longer than DEAD.
module pwm_deadtime #(
    parameter int DEAD = 1
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic raw,
    output logic pwm,
    output logic pwm_n
);

    logic [1:0] dead_cnt_r;
    logic       prev_raw_r;
    logic       pwm_r;
    logic       pwm_n_r;

    // Any change of raw forces both outputs low and restarts the dead-time window.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            dead_cnt_r <= 2'd0;
            prev_raw_r <= 1'b0;
            pwm_r      <= 1'b0;
            pwm_n_r    <= 1'b0;
        end else begin
            prev_raw_r <= raw;
            if (raw != prev_raw_r) begin
                dead_cnt_r <= 2'(DEAD - 1);
                pwm_r      <= 1'b0;
                pwm_n_r    <= 1'b0;
            end else if (dead_cnt_r != 2'd0) begin
                dead_cnt_r <= dead_cnt_r - 2'd1;
                pwm_r      <= 1'b0;
                pwm_n_r    <= 1'b0;
            end else begin
                dead_cnt_r <= 2'd0;
                pwm_r      <= raw;
                pwm_n_r    <= !raw;
            end
        end
    end

    assign pwm   = pwm_r;
    assign pwm_n = pwm_n_r;

endmodule

// File: rtl/pwm_from_counter.sv
// PWM generator driven by an upstream wrap counter, with double-buffered duty and
// period tick. Define PWM_DEADTIME_EN to add PWM_N and dead-time shaping.
module pwm_from_counter
    import pwm_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int PERIODS = 8,
    parameter int DEAD    = 1
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [WIDTH-1:0] COUNT,
    input  logic             WRAP,
    input  logic             EN,
    input  logic [WIDTH:0]   DUTY,
    input  logic             DUTY_VALID,
    output logic             DUTY_READY,
    output logic             PWM,
`ifdef PWM_DEADTIME_EN
    output logic             PWM_N,
`endif
    output logic             PERIOD_TICK,
    output logic             RUNNING
);

    localparam int DUTY_MAX = (WIDTH == WIDTH_DEF) ? MAX_DUTY : (1 << WIDTH);

    pwm_state_e     state_r;
    pwm_state_e     state_next_s;
    logic [WIDTH:0] shadow_r;
    logic [WIDTH:0] active_r;
    logic [WIDTH:0] duty_clamped_s;
    logic           shadow_full_r;
    logic           hs_s;
    logic           xfer_s;
    logic           in_run_s;
    logic           raw_s;
    logic           period_end_s;
    logic [7:0]     period_cnt_r;
    logic           tick_r;
    logic           running_r;

    assign duty_clamped_s = (WIDTH+1)'(clamp_duty(32'(DUTY), 32'(DUTY_MAX)));
    assign hs_s           = DUTY_VALID && !shadow_full_r;
    assign xfer_s         = WRAP && shadow_full_r;
    assign in_run_s       = (state_r == RUN) || (state_r == STOP_PEND);
    assign period_end_s   = WRAP && in_run_s && (period_cnt_r == 8'(PERIODS - 1));

    // Next-state logic; EN returning during STOP_PEND wins over the closing wrap.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE:      if (EN) state_next_s = ARM; else state_next_s = IDLE;
            ARM:       if (!EN) state_next_s = IDLE; else if (WRAP) state_next_s = RUN; else state_next_s = ARM;
            RUN:       if (!EN) state_next_s = STOP_PEND; else state_next_s = RUN;
            STOP_PEND: if (EN) state_next_s = RUN; else if (WRAP) state_next_s = IDLE; else state_next_s = STOP_PEND;
            default:   state_next_s = IDLE;
        endcase
    end

    // Raw compare against the active duty; COUNT zero-extended so duty 2^WIDTH means always high.
    always_comb begin
        raw_s = 1'b0;
        if (in_run_s) begin
            raw_s = ({1'b0, COUNT} < active_r);
        end else begin
            raw_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Shadow/active duty pair; a handshake can only happen while the shadow is empty.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            shadow_r      <= '0;
            shadow_full_r <= 1'b0;
            active_r      <= '0;
        end else begin
            if (xfer_s) begin
                active_r <= shadow_r;
            end
            if (hs_s) begin
                shadow_r      <= duty_clamped_s;
                shadow_full_r <= 1'b1;
            end else if (xfer_s) begin
                shadow_full_r <= 1'b0;
            end
        end
    end

    // Period counter and tick; the count is dropped whenever the FSM heads for IDLE.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            period_cnt_r <= 8'd0;
            tick_r       <= 1'b0;
            running_r    <= 1'b0;
        end else begin
            tick_r    <= period_end_s;
            running_r <= (state_next_s == RUN) || (state_next_s == STOP_PEND);
            if (state_next_s == IDLE) begin
                period_cnt_r <= 8'd0;
            end else if (period_end_s) begin
                period_cnt_r <= 8'd0;
            end else if (WRAP && in_run_s) begin
                period_cnt_r <= period_cnt_r + 8'd1;
            end
        end
    end

`ifdef PWM_DEADTIME_EN
    pwm_deadtime #(
        .DEAD(DEAD)
    ) u_deadtime (
        .CLK   (CLK),
        .RESETN(RESETN),
        .raw   (raw_s),
        .pwm   (PWM),
        .pwm_n (PWM_N)
    );
`else
    logic pwm_r;

    // Output register for the plain PWM path.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            pwm_r <= 1'b0;
        end else begin
            pwm_r <= raw_s;
        end
    end

    assign PWM = pwm_r;
`endif

    assign DUTY_READY  = !shadow_full_r;
    assign PERIOD_TICK = tick_r;
    assign RUNNING     = running_r;

endmodule

// File: tb/tb_pwm_from_counter.sv
// Directed bench for pwm_from_counter: the bench plays the upstream 4-bit counter
// and scoreboards PWM one cycle behind each COUNT, with PERIODS=3.
module tb_pwm_from_counter;

    logic       real_clk = 1'b0;
    logic       resetn;
    logic [3:0] count;
    logic       wrap;
    logic       en;
    logic [4:0] duty;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm;
`ifdef PWM_DEADTIME_EN
    logic       pwm_n;
`endif
    logic       period_tick;
    logic       running;

    int compared   = 0;
    int mismatched = 0;
    int cnt_v      = 0;
    int pcount_v   = 0;
    bit exp_q[$];

    always #5 real_clk = ~real_clk;

    pwm_from_counter #(
        .WIDTH  (4),
        .PERIODS(3),
        .DEAD   (2)
    ) dut (
        .CLK        (real_clk),
        .RESETN     (resetn),
        .COUNT      (count),
        .WRAP       (wrap),
        .EN         (en),
        .DUTY       (duty),
        .DUTY_VALID (duty_valid),
        .DUTY_READY (duty_ready),
        .PWM        (pwm),
`ifdef PWM_DEADTIME_EN
        .PWM_N      (pwm_n),
`endif
        .PERIOD_TICK(period_tick),
        .RUNNING    (running)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d (count %0d)", tag, obs, exp, cnt_v);
        end
    endtask

    // One counter cycle: drive COUNT/WRAP, queue the expected PWM, check after the edge.
    task automatic step(input int act, input bit run);
        bit e_pwm;
        bit e_tick;
        count  = cnt_v[3:0];
        wrap   = (cnt_v == 15);
        e_pwm  = run && (cnt_v < act);
        e_tick = 1'b0;
        if (wrap && run) begin
            if (pcount_v == 2) begin
                e_tick   = 1'b1;
                pcount_v = 0;
            end else begin
                pcount_v++;
            end
        end
        exp_q.push_back(e_pwm);
        @(posedge real_clk);
        #1;
        e_pwm = exp_q.pop_front();
`ifdef PWM_DEADTIME_EN
        chk("pwm_overlap", 32'(pwm && pwm_n), 32'd0);
`else
        chk("pwm", 32'(pwm), 32'(e_pwm));
`endif
        chk("tick", 32'(period_tick), 32'(e_tick));
        cnt_v = (cnt_v + 1) % 16;
    endtask

    task automatic run_to(input int last, input int act, input bit run);
        do begin
            step(act, run);
        end while (cnt_v != (last + 1) % 16);
    endtask

    task automatic offer(input logic [4:0] d, input int act, input bit run);
        duty       = d;
        duty_valid = 1'b1;
        chk("ready_pre", 32'(duty_ready), 32'd1);
        step(act, run);
        duty_valid = 1'b0;
        chk("ready_post", 32'(duty_ready), 32'd0);
    endtask

    initial begin
        resetn     = 1'b0;
        en         = 1'b0;
        duty       = 5'd0;
        duty_valid = 1'b0;
        count      = 4'd0;
        wrap       = 1'b0;

        run_to(3, 0, 1'b0);
        chk("rst_ready", 32'(duty_ready), 32'd1);
        chk("rst_running", 32'(running), 32'd0);
        resetn = 1'b1;

        // Load 8 while idle, arm, and start at the next COUNT=0.
        offer(5'd8, 0, 1'b0);
        en = 1'b1;
        run_to(15, 0, 1'b0);
        chk("ready_after_xfer", 32'(duty_ready), 32'd1);
        chk("running_on", 32'(running), 32'd1);
        run_to(15, 8, 1'b1);

        // Duty 0, then 16, then 20 clamped to 16.
        run_to(1, 8, 1'b1);
        offer(5'd0, 8, 1'b1);
        run_to(15, 8, 1'b1);
        run_to(2, 0, 1'b1);
        offer(5'd16, 0, 1'b1);
        run_to(15, 0, 1'b1);
        run_to(2, 16, 1'b1);
        offer(5'd20, 16, 1'b1);
        run_to(15, 16, 1'b1);

        // 4 accepted mid-period, 12 held off until the shadow drains at the wrap.
        run_to(4, 16, 1'b1);
        offer(5'd4, 16, 1'b1);
        duty       = 5'd12;
        duty_valid = 1'b1;
        run_to(15, 16, 1'b1);
        chk("ready_wrap", 32'(duty_ready), 32'd1);
        step(4, 1'b1);
        duty_valid = 1'b0;
        chk("ready_second", 32'(duty_ready), 32'd0);
        run_to(15, 4, 1'b1);
        run_to(15, 12, 1'b1);

        // EN drops at COUNT=5: the period completes, then idle.
        run_to(4, 12, 1'b1);
        en = 1'b0;
        run_to(15, 12, 1'b1);
        chk("running_off", 32'(running), 32'd0);
        pcount_v = 0;
        run_to(2, 0, 1'b0);
        en = 1'b1;
        run_to(15, 0, 1'b0);
        chk("running_rearm", 32'(running), 32'd1);

        // EN dropped at 5 and restored at 10 keeps the waveform intact.
        run_to(4, 12, 1'b1);
        en = 1'b0;
        run_to(9, 12, 1'b1);
        chk("running_stop_pend", 32'(running), 32'd1);
        en = 1'b1;
        run_to(15, 12, 1'b1);
        run_to(15, 12, 1'b1);
        run_to(15, 12, 1'b1);

        // Reset mid-period with a pending shadow value.
        run_to(3, 12, 1'b1);
        offer(5'd5, 12, 1'b1);
        step(12, 1'b1);
        resetn = 1'b0;
        step(12, 1'b0);
        chk("midrst_ready", 32'(duty_ready), 32'd1);
        chk("midrst_running", 32'(running), 32'd0);
        resetn = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
